// File: rtl/counter_pkg.sv
// Shared constants for the counter_pwm slice: FSM encodings and the
// all-ones count helper used to detect the counter wrap.
package counter_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    // All-ones value of a bus_width-bit counter (the count just before wrap).
    function automatic logic [31:0] CNT_MAX(input int unsigned bus_width);
        return (32'd1 << bus_width) - 32'd1;
    endfunction

endpackage

// File: rtl/counter_pwm_dbuf.sv
// Double-buffered duty register: a one-deep pending slot filled through a
// valid/ready handshake, and an active value that only changes on a
// counter wrap so that a period is never cut short or stretched.
module counter_pwm_dbuf
    import counter_pkg::*;
#(
    parameter int bus_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 boundary,
    input  logic [bus_width-1:0] duty,
    input  logic                 duty_valid,
    output logic                 duty_ready,
    output logic [bus_width-1:0] active
);

    logic [bus_width-1:0] pending;
    logic                 pending_full;
    logic                 xfer;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign duty_ready = !pending_full && !rst;
    assign xfer       = duty_valid && duty_ready;

    // Pending/active update: drain pending at a wrap, or bypass straight to
    // active when the slot is empty and a value arrives on the wrap itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            pending_full <= 1'b0;
            active       <= '0;
        end else if (boundary) begin
            if (pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end else if (xfer) begin
                active       <= duty;
            end else begin
                active       <= active;
            end
        end else if (xfer) begin
            pending      <= duty;
            pending_full <= 1'b1;
        end else begin
            pending_full <= pending_full;
        end
    end

endmodule

// File: rtl/counter_pwm.sv
// PWM generator slaved to an external free-running counter. Start and stop
// are aligned to the counter wrap; the compare uses the double-buffered
// duty so every period is complete and glitch-free.
module counter_pwm
    import counter_pkg::*;
#(
    parameter int bus_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ebl,
    input  logic [bus_width-1:0] cnt,
    input  logic [bus_width-1:0] duty,
    input  logic                 duty_valid,
    output logic                 duty_ready,
    input  logic                 stop,
    output logic                 pwm,
    output logic                 period_end,
    output logic                 running
);

    localparam logic [bus_width-1:0] CNT_TOP = bus_width'(CNT_MAX(bus_width));

    logic                 boundary;
    logic [bus_width-1:0] active;
    logic [1:0]           state;
    logic [1:0]           next_state;
    logic                 pwm_next;

    // The counter wraps on this edge.
    assign boundary = ebl && (cnt == CNT_TOP);

    counter_pwm_dbuf #(
        .bus_width (bus_width)
    ) u_dbuf (
        .clk        (clk),
        .rst        (rst),
        .boundary   (boundary),
        .duty       (duty),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .active     (active)
    );

    // Next-state logic: every transition except entering STOPPING waits for a wrap.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (boundary) next_state = ST_RUN;
                else          next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (stop) next_state = ST_STOPPING;
                else      next_state = ST_RUN;
            end
            ST_STOPPING: begin
                if (boundary) next_state = ST_IDLE;
                else          next_state = ST_STOPPING;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Compare value: low when idle or leaving to idle, frozen when the counter is.
    always_comb begin
        pwm_next = pwm;
        if ((state == ST_IDLE) || (next_state == ST_IDLE)) begin
            pwm_next = 1'b0;
        end else if (ebl) begin
            pwm_next = (cnt < active);
        end else begin
            pwm_next = pwm;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pwm        <= 1'b0;
            period_end <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= next_state;
            pwm        <= pwm_next;
            period_end <= boundary && (state != ST_IDLE);
            running    <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_counter_pwm.sv
// Scoreboard bench for counter_pwm at bus_width=4. The stimulus process
// drives inputs on the falling edge and queues the outputs expected after
// the following rising edge; a monitor pops and compares after each edge.
module tb_counter_pwm;

    typedef struct packed {
        logic [7:0] tag;
        logic [3:0] bits;   // {pwm, period_end, running, duty_ready}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ebl;
    logic [3:0] cnt;
    logic [3:0] duty;
    logic       duty_valid;
    logic       duty_ready;
    logic       stop;
    logic       pwm;
    logic       period_end;
    logic       running;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] mon_act;
    logic [7:0] tag;
    int         n_vec  = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    // Upstream free-running counter sharing rst and ebl with the DUT.
    always_ff @(posedge clk) begin
        if (rst)      cnt <= 4'd0;
        else if (ebl) cnt <= cnt + 4'd1;
        else          cnt <= cnt;
    end

    counter_pwm #(
        .bus_width (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ebl        (ebl),
        .cnt        (cnt),
        .duty       (duty),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .stop       (stop),
        .pwm        (pwm),
        .period_end (period_end),
        .running    (running)
    );

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = {pwm, period_end, running, duty_ready};
            n_vec++;
            if (mon_act !== mon_e.bits) begin
                n_miss++;
                $display("FAIL test%0d vec%0d: pwm/pe/run/rdy got %b expected %b",
                         mon_e.tag, n_vec, mon_act, mon_e.bits);
            end
        end
    end

    task automatic tick(input logic p, input logic pe, input logic r, input logic rd);
        exp_t e;
        e.tag  = tag;
        e.bits = {p, pe, r, rd};
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // One enabled cycle while running with duty d.
    task automatic rc(input logic [3:0] d, input logic run_after, input logic rd);
        tick(run_after && (cnt < d), cnt == 4'd15, run_after, rd);
    endtask

    // One cycle in IDLE (run_after high on the wrap that starts RUN).
    task automatic ic(input logic run_after);
        tick(1'b0, 1'b0, run_after, 1'b1);
    endtask

    // A full running period at duty d, optionally sending a value at cnt=0
    // (s0/v0) or on the wrap cycle (s15/v15); pending assumed empty on entry.
    task automatic run_period(input logic [3:0] d, input logic s0, input logic [3:0] v0,
                              input logic s15, input logic [3:0] v15);
        for (int i = 0; i < 16; i++) begin
            duty_valid = ((cnt == 4'd0) && s0) || ((cnt == 4'd15) && s15);
            duty       = (cnt == 4'd0) ? v0 : v15;
            rc(d, 1'b1, s0 ? (cnt == 4'd15) : 1'b1);
        end
        duty_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ebl = 1'b1; stop = 1'b0; duty = 4'd0; duty_valid = 1'b0;

        // 1: reset values, duty 5 accepted in IDLE, start at first wrap
        tag = 8'd1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        duty = 4'd5; duty_valid = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        duty_valid = 1'b0;
        while (cnt != 4'd15) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        run_period(4'd5, 1'b0, 4'd0, 1'b0, 4'd0);
        run_period(4'd5, 1'b0, 4'd0, 1'b0, 4'd0);

        // 2: duty 0 then 15, then queue 8
        tag = 8'd2;
        run_period(4'd5,  1'b1, 4'd0,  1'b0, 4'd0);
        run_period(4'd0,  1'b1, 4'd15, 1'b0, 4'd0);
        run_period(4'd15, 1'b1, 4'd8,  1'b0, 4'd0);

        // 3: at duty 8 send 3 mid-period, 12 stalls until the wrap
        tag = 8'd3;
        for (int i = 0; i < 16; i++) begin
            duty_valid = (cnt >= 4'd6);
            duty       = (cnt == 4'd6) ? 4'd3 : 4'd12;
            rc(4'd8, 1'b1, (cnt < 4'd6) || (cnt == 4'd15));
        end
        run_period(4'd3, 1'b1, 4'd12, 1'b0, 4'd0);

        // 4: transfer on the wrap cycle with pending empty
        tag = 8'd4;
        run_period(4'd12, 1'b0, 4'd0, 1'b1, 4'd10);
        run_period(4'd10, 1'b0, 4'd0, 1'b0, 4'd0);

        // 5: stop pulse at cnt=7, ignored stop in IDLE, stop on the wrap
        tag = 8'd5;
        for (int i = 0; i < 16; i++) begin
            stop = (cnt == 4'd7);
            rc(4'd10, cnt != 4'd15, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            stop = (cnt == 4'd3);
            ic(cnt == 4'd15);
        end
        for (int i = 0; i < 16; i++) begin
            stop = (cnt == 4'd15);
            rc(4'd10, 1'b1, 1'b1);
        end
        stop = 1'b0;
        for (int i = 0; i < 16; i++) rc(4'd10, cnt != 4'd15, 1'b1);
        for (int i = 0; i < 16; i++) ic(cnt == 4'd15);

        // 6: enable low for 5 cycles at cnt=10 freezes pwm
        tag = 8'd6;
        while (cnt != 4'd10) rc(4'd10, 1'b1, 1'b1);
        ebl = 1'b0;
        repeat (5) tick(1'b1, 1'b0, 1'b1, 1'b1);
        ebl = 1'b1;
        while (cnt != 4'd15) rc(4'd10, 1'b1, 1'b1);
        rc(4'd10, 1'b1, 1'b1);

        // 7: reset mid-RUN with pending full; pending must be lost
        tag = 8'd7;
        duty = 4'd2; duty_valid = 1'b1;
        rc(4'd10, 1'b1, 1'b0);
        duty_valid = 1'b0;
        while (cnt != 4'd4) rc(4'd10, 1'b1, 1'b0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        while (cnt != 4'd15) ic(1'b0);
        ic(1'b1);
        for (int i = 0; i < 16; i++) rc(4'd0, 1'b1, 1'b1);

        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
